// File: rtl/program_counter_stack_pkg.sv
// Shared definitions for the program counter / return-stack block.
//   MODE_*  : 3-bit operation codes carried on MODE
//   leds_t  : bundle of the per-event status pulses
package pc_stack_pkg;
  localparam logic [2:0] MODE_SEQ  = 3'b000;
  localparam logic [2:0] MODE_JMP  = 3'b001;
  localparam logic [2:0] MODE_BRR  = 3'b010;
  localparam logic [2:0] MODE_CALL = 3'b011;
  localparam logic [2:0] MODE_RET  = 3'b100;

  typedef struct packed {
    logic wpc;
    logic jmp;
    logic call;
    logic ret;
  } leds_t;
endpackage

// File: rtl/program_counter_stack_return_stack.sv
// return_stack: DEPTH x AW LIFO for return addresses.
//   CLK/RESET : falling-edge clock, async active-high reset (clears count only)
//   push_i/din_i : push din_i when not full
//   pop_i     : drop top entry when not empty
//   top_o     : current top entry (don't-care when empty)
//   count_o/full_o/empty_o : occupancy status
module return_stack
  import pc_stack_pkg::*;
#(
  parameter int AW    = 11,
  parameter int DEPTH = 8,
  localparam int SPW  = $clog2(DEPTH) + 1,
  localparam int AIW  = $clog2(DEPTH)
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [AW-1:0]  din_i,
  output logic [AW-1:0]  top_o,
  output logic [SPW-1:0] count_o,
  output logic           full_o,
  output logic           empty_o
);
  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] count_q, count_d;
  logic [AIW-1:0] wr_idx, top_idx;
  logic           do_push, do_pop;

  assign full_o  = (count_q == SPW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  // push has priority; the controller never asserts both together
  assign do_pop  = pop_i & ~push_i & ~empty_o;
  assign wr_idx  = AIW'(count_q);
  assign top_idx = AIW'(count_q - SPW'(1));
  assign top_o   = mem_q[top_idx];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push)     count_d = count_q + SPW'(1);
    else if (do_pop) count_d = count_q - SPW'(1);
  end

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) count_q <= '0;
    else       count_q <= count_d;
  end

  // Storage has no reset: contents are meaningless until pushed.
  always_ff @(negedge CLK) begin
    if (do_push && !RESET) mem_q[wr_idx] <= din_i;
  end
endmodule

// File: rtl/program_counter_stack.sv
// program_counter_stack: PC register with next-PC mux, return stack,
// sticky stack-error flags and one-cycle event LEDs.
//   CLK (falling edge), RESET (async, active-high)
//   WPC, MODE, COND_ALU, COND_UC, DIN : update controls from the control unit
//   DOUT : current PC;  SP/STK_FULL/STK_EMPTY : stack status
//   ERR_OVF/ERR_UDF : sticky CALL-on-full / RET-on-empty
//   LED_WPC/JMP/CALL/RET : pulses for the cycle after the matching update
module program_counter_stack
  import pc_stack_pkg::*;
#(
  parameter int AW    = 11,
  parameter int DEPTH = 8,
  localparam int SPW  = $clog2(DEPTH) + 1
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           WPC,
  input  logic [2:0]     MODE,
  input  logic           COND_ALU,
  input  logic           COND_UC,
  input  logic [AW-1:0]  DIN,
  output logic [AW-1:0]  DOUT,
  output logic [SPW-1:0] SP,
  output logic           STK_FULL,
  output logic           STK_EMPTY,
  output logic           ERR_OVF,
  output logic           ERR_UDF,
  output logic           LED_WPC,
  output logic           LED_JMP,
  output logic           LED_CALL,
  output logic           LED_RET
);
  logic [AW-1:0] pc_q, pc_d, pc_next, stk_top;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  leds_t         led_q, led_d;
  logic          take, push, pop, full, empty;

  assign take    = COND_ALU | COND_UC;
  assign pc_next = pc_q + AW'(1);

  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    led_d = '0;
    push  = 1'b0;
    pop   = 1'b0;
    if (WPC) begin
      led_d.wpc = 1'b1;
      pc_d      = pc_next;
      case (MODE)
        MODE_JMP: if (take) begin
          pc_d      = DIN;
          led_d.jmp = 1'b1;
        end
        // DIN is a two's-complement offset; plain modular add handles the sign
        MODE_BRR: if (take) begin
          pc_d      = pc_next + DIN;
          led_d.jmp = 1'b1;
        end
        MODE_CALL: if (take) begin
          if (full) ovf_d = 1'b1;
          else begin
            push       = 1'b1;
            pc_d       = DIN;
            led_d.call = 1'b1;
          end
        end
        MODE_RET: begin
          if (empty) udf_d = 1'b1;
          else begin
            pop       = 1'b1;
            pc_d      = stk_top;
            led_d.ret = 1'b1;
          end
        end
        default: ;  // SEQ and reserved codes
      endcase
    end
  end

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      led_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      led_q <= led_d;
    end
  end

  return_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .CLK     (CLK),
    .RESET   (RESET),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_next),
    .top_o   (stk_top),
    .count_o (SP),
    .full_o  (full),
    .empty_o (empty)
  );

  assign DOUT      = pc_q;
  assign STK_FULL  = full;
  assign STK_EMPTY = empty;
  assign ERR_OVF   = ovf_q;
  assign ERR_UDF   = udf_q;
  assign LED_WPC   = led_q.wpc;
  assign LED_JMP   = led_q.jmp;
  assign LED_CALL  = led_q.call;
  assign LED_RET   = led_q.ret;
endmodule

// File: tb/tb_program_counter_stack.sv
module tb_program_counter_stack;
  localparam int AW = 11, DEPTH = 8, SPW = 4;
  localparam int PCMOD = 1 << AW;

  logic CLK = 1'b1, RESET = 1'b0, WPC = 1'b0, COND_ALU = 1'b0, COND_UC = 1'b0;
  logic [2:0] MODE = 3'd0;
  logic [AW-1:0] DIN = '0, DOUT;
  logic [SPW-1:0] SP;
  logic STK_FULL, STK_EMPTY, ERR_OVF, ERR_UDF, LED_WPC, LED_JMP, LED_CALL, LED_RET;

  program_counter_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET), .WPC(WPC), .MODE(MODE), .COND_ALU(COND_ALU),
    .COND_UC(COND_UC), .DIN(DIN), .DOUT(DOUT), .SP(SP), .STK_FULL(STK_FULL),
    .STK_EMPTY(STK_EMPTY), .ERR_OVF(ERR_OVF), .ERR_UDF(ERR_UDF), .LED_WPC(LED_WPC),
    .LED_JMP(LED_JMP), .LED_CALL(LED_CALL), .LED_RET(LED_RET));

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;

  // reference model: PC as integer, stack as a queue of return addresses
  int m_pc = 0;
  int m_stk[$];
  bit m_ovf = 0, m_udf = 0, l_wpc = 0, l_jmp = 0, l_call = 0, l_ret = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".dout"},  32'(DOUT), 32'(m_pc));
    chk({tag, ".sp"},    32'(SP), 32'(m_stk.size()));
    chk({tag, ".full"},  32'(STK_FULL), 32'(m_stk.size() == DEPTH));
    chk({tag, ".empty"}, 32'(STK_EMPTY), 32'(m_stk.size() == 0));
    chk({tag, ".ovf"},   32'(ERR_OVF), 32'(m_ovf));
    chk({tag, ".udf"},   32'(ERR_UDF), 32'(m_udf));
    chk({tag, ".lwpc"},  32'(LED_WPC), 32'(l_wpc));
    chk({tag, ".ljmp"},  32'(LED_JMP), 32'(l_jmp));
    chk({tag, ".lcall"}, 32'(LED_CALL), 32'(l_call));
    chk({tag, ".lret"},  32'(LED_RET), 32'(l_ret));
  endtask

  function automatic void model_reset();
    m_pc = 0; m_stk.delete(); m_ovf = 0; m_udf = 0;
    l_wpc = 0; l_jmp = 0; l_call = 0; l_ret = 0;
  endfunction

  function automatic void model_op(bit w, int m, bit take, int din);
    int nxt = (m_pc + 1) % PCMOD;
    l_wpc = w; l_jmp = 0; l_call = 0; l_ret = 0;
    if (!w) return;
    m_pc = nxt;
    if (m == 1 && take) begin m_pc = din; l_jmp = 1; end
    else if (m == 2 && take) begin m_pc = (nxt + din) % PCMOD; l_jmp = 1; end
    else if (m == 3 && take) begin
      if (m_stk.size() == DEPTH) m_ovf = 1;
      else begin m_stk.push_back(nxt); m_pc = din; l_call = 1; end
    end else if (m == 4) begin
      if (m_stk.size() == 0) m_udf = 1;
      else begin m_pc = m_stk.pop_back(); l_ret = 1; end
    end
  endfunction

  // one update: drive after the rising edge, check just after the falling edge
  task automatic op(input string tag, input bit w, input int m, input bit ca, input bit cu,
                    input int din);
    @(posedge CLK); #1;
    WPC = w; MODE = 3'(m); COND_ALU = ca; COND_UC = cu; DIN = AW'(din);
    @(negedge CLK); #1;
    model_op(w, m, ca | cu, din);
    chk_all(tag);
  endtask

  // reset asserted with a CALL pending so an edge occurs while it is held
  task automatic do_reset(input string tag);
    @(posedge CLK); #1;
    WPC = 1; MODE = 3'd3; COND_UC = 1; DIN = AW'(11'h3AA);
    RESET = 1; #1;
    model_reset();
    chk_all({tag, ".async"});
    @(negedge CLK); #1;
    chk_all({tag, ".held"});
    @(posedge CLK); #1;
    RESET = 0; WPC = 0; COND_UC = 0;
  endtask

  initial begin
    model_reset();
    do_reset("rst0");

    // 1: hold with WPC=0, then reset mid-run
    op("t1_seq", 1, 0, 0, 0, 0);
    op("t1_seq", 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) op("t1_hold", 0, 1, 1, 1, 11'h7F);
    chk("t1_holdpc", 32'(DOUT), 32'd2);
    op("t1_call", 1, 3, 0, 1, 11'h40);
    do_reset("t1_rst");

    // 2: SEQ wrap from 2046; LED_WPC drops when WPC idles
    op("t2_jmp", 1, 1, 1, 0, 2046);
    op("t2_seq", 1, 0, 0, 0, 0);
    chk("t2_2047", 32'(DOUT), 32'd2047);
    op("t2_wrap", 1, 0, 0, 0, 0);
    chk("t2_zero", 32'(DOUT), 32'd0);
    op("t2_idle", 0, 0, 0, 0, 0);
    chk("t2_ledoff", 32'(LED_WPC), 32'd0);

    // 3: JMP not taken / taken, BRR backwards
    op("t3_jnt", 1, 1, 0, 0, 11'h155);
    op("t3_jt", 1, 1, 0, 1, 11'h155);
    chk("t3_155", 32'(DOUT), 32'h155);
    op("t3_to9", 1, 1, 1, 0, 9);
    op("t3_seq", 1, 0, 0, 0, 0);
    op("t3_brr", 1, 2, 1, 0, 2048 - 4);
    chk("t3_brr7", 32'(DOUT), 32'd7);

    // 4: nested CALL/RET
    op("t4_to5", 1, 1, 0, 1, 5);
    op("t4_c1", 1, 3, 0, 1, 11'h100);
    op("t4_c2", 1, 3, 1, 0, 11'h200);
    chk("t4_200", 32'(DOUT), 32'h200);
    op("t4_r1", 1, 4, 0, 0, 0);
    chk("t4_101", 32'(DOUT), 32'h101);
    op("t4_r2", 1, 4, 0, 0, 0);
    chk("t4_6", 32'(DOUT), 32'd6);

    // 5: overflow on the ninth CALL
    do_reset("t5_rst");
    for (int i = 0; i < 9; i++) op("t5_call", 1, 3, 1, 1, 11'h10 + i);
    chk("t5_ovf", 32'(ERR_OVF), 32'd1);
    chk("t5_sp", 32'(SP), 32'd8);

    // 6: underflow is sticky; reserved mode acts as SEQ
    do_reset("t6_rst");
    op("t6_ret", 1, 4, 0, 0, 0);
    chk("t6_udf", 32'(ERR_UDF), 32'd1);
    op("t6_call", 1, 3, 1, 0, 11'h300);
    op("t6_r", 1, 4, 1, 1, 0);
    op("t6_res", 1, 7, 1, 1, 11'h555);
    op("t6_res5", 1, 5, 1, 1, 11'h555);
    chk("t6_sticky", 32'(ERR_UDF), 32'd1);
    do_reset("t6_clr");

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset("rnd_rst");
      else op("rnd", $urandom_range(0, 7) != 0, $urandom_range(0, 7),
              1'($urandom), 1'($urandom), int'($urandom_range(0, PCMOD - 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
